// File: rtl/ham_pkg.sv
// ham_pkg: shared Hamming(15,11) definitions for the encoder stream and the
// decoder-side models.
//   HAM_N / HAM_K / HAM_P : codeword, data and parity bit counts
//   HAM_PAR_POS           : parity positions (powers of two)
//   ham_word_t            : data word plus injection position, as held in S1
//   ham_encode()          : position-indexed even-parity encoder, [11:1] -> [15:1]
package ham_pkg;

    localparam int unsigned HAM_N = 15;
    localparam int unsigned HAM_K = 11;
    localparam int unsigned HAM_P = 4;
    localparam int unsigned HAM_PAR_POS [HAM_P] = '{1, 2, 4, 8};

    typedef logic [HAM_K:1] ham_data_t;
    typedef logic [HAM_N:1] ham_code_t;
    typedef logic [3:0]     ham_pos_t;

    typedef struct packed {
        ham_data_t data;
        ham_pos_t  flip;
    } ham_word_t;

    // Data bits fill the non-power-of-two positions in ascending order; each
    // parity bit is then the XOR of every position whose index has its bit set
    // (parity positions are still zero at that point, so they drop out).
    function automatic ham_code_t ham_encode(input ham_data_t data);
        ham_code_t   cw;
        int unsigned d;
        logic        p;
        cw = '0;
        d  = 1;
        for (int unsigned pos = 1; pos <= HAM_N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[4'(pos)] = data[4'(d)];
                d++;
            end
        end
        for (int unsigned j = 0; j < HAM_P; j++) begin
            p = 1'b0;
            for (int unsigned pos = 1; pos <= HAM_N; pos++) begin
                if (((pos >> j) & 1) != 0) p ^= cw[4'(pos)];
            end
            cw[4'(HAM_PAR_POS[j])] = p;
        end
        return cw;
    endfunction

endpackage

// File: rtl/ham_sync_fifo.sv
// ham_sync_fifo: single-clock FIFO with modulo-DEPTH pointers (any DEPTH >= 2).
//   clock, reset : posedge clock, synchronous active-high reset
//   wr_en        : write wr_data this edge (caller guarantees not full)
//   rd_en        : pop the head this edge (caller guarantees not empty)
//   rd_data      : head entry, combinational from the storage array
//   count        : current occupancy, 0..DEPTH
module ham_sync_fifo #(
    parameter  int unsigned WIDTH = 15,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ham_encode_stream.sv
// ham_encode_stream: streaming Hamming(15,11) encoder with per-word single-bit
// error injection and an output FIFO.
//   clock, reset         : posedge clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data[11:1] data, in_flip 0 = clean,
//                          1..15 = invert that codeword position
//   out_valid/out_ready  : output handshake; out_ham[15:1] position-indexed codeword
//   word_count           : output handshakes so far, wraps at 2^CNT_W
module ham_encode_stream
    import ham_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [HAM_K:1]   in_data,
    input  logic [3:0]       in_flip,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HAM_N:1]   out_ham,
    output logic [CNT_W-1:0] word_count
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    ham_word_t        s1_word;
    logic             s1_valid;
    ham_code_t        flip_mask;
    ham_code_t        s1_code;
    ham_code_t        fifo_head;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W:0]   reserved;
    logic             accept;
    logic             pop;

    // S1 never stalls, so a word is only accepted if a FIFO slot is still free
    // after counting the word already sitting in S1.
    assign reserved  = {1'b0, occupancy} + (OCC_W + 1)'(s1_valid);
    assign in_ready  = !reset && (reserved < (OCC_W + 1)'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = !reset && (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign out_ham   = out_valid ? fifo_head : '0;

    always_ff @(posedge clock) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= accept;
        if (accept) s1_word <= {in_data, in_flip};
    end

    // Injection is applied after encoding; parity is deliberately left as-is.
    always_comb begin
        flip_mask = '0;
        if (s1_word.flip != '0) flip_mask[s1_word.flip] = 1'b1;
        s1_code = ham_encode(s1_word.data) ^ flip_mask;
    end

    ham_sync_fifo #(
        .WIDTH(HAM_N),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (s1_valid),
        .wr_data(s1_code),
        .rd_en  (pop),
        .rd_data(fifo_head),
        .count  (occupancy)
    );

    always_ff @(posedge clock) begin
        if (reset)    word_count <= '0;
        else if (pop) word_count <= word_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_ham_encode_stream.sv
// tb_ham_encode_stream: directed and randomised bench for ham_encode_stream
// (DEPTH=4, CNT_W=16). Reference encoding is built independently via syndrome
// placement; hamfix() is a single-error-correcting decoder model.
module tb_ham_encode_stream;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [11:1]      in_data;
    logic [3:0]       in_flip;
    logic             out_valid;
    logic             out_ready;
    logic [15:1]      out_ham;
    logic [CNT_W-1:0] word_count;

    int unsigned      errors = 0;
    int unsigned      checks = 0;
    logic [CNT_W-1:0] exp_count = '0;

    typedef struct {
        logic [11:1] data;
        logic [3:0]  flip;
        logic [15:1] code;
    } vec_t;

    vec_t flip_vecs [8] = '{
        '{11'h001, 4'd0,  15'h0007},
        '{11'h001, 4'd5,  15'h0017},
        '{11'h7FF, 4'd1,  15'h7FFE},
        '{11'h7FF, 4'd15, 15'h3FFF},
        '{11'h000, 4'd8,  15'h0080},
        '{11'h001, 4'd3,  15'h0003},
        '{11'h400, 4'd0,  15'h408B},
        '{11'h002, 4'd0,  15'h0019}
    };

    always #5 clock = ~clock;

    ham_encode_stream #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flip   (in_flip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ham   (out_ham),
        .word_count(word_count)
    );

    function automatic logic [3:0] syndrome(input logic [15:1] cw);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k <= 15; k++) if (cw[4'(k)]) s ^= 4'(k);
        return s;
    endfunction

    function automatic logic [15:1] enc_model(input logic [11:1] d);
        logic [15:1] cw;
        logic [3:0]  s;
        cw = '0;
        cw[3]  = d[1];  cw[5]  = d[2];  cw[6]  = d[3];  cw[7]  = d[4];
        cw[9]  = d[5];  cw[10] = d[6];  cw[11] = d[7];  cw[12] = d[8];
        cw[13] = d[9];  cw[14] = d[10]; cw[15] = d[11];
        s = syndrome(cw);
        cw[1] = s[0]; cw[2] = s[1]; cw[4] = s[2]; cw[8] = s[3];
        return cw;
    endfunction

    function automatic logic [15:1] hamfix(input logic [15:1] cw);
        logic [15:1] r;
        logic [3:0]  s;
        r = cw;
        s = syndrome(cw);
        if (s != 4'd0) r[s] = ~r[s];
        return r;
    endfunction

    function automatic logic [15:1] flip_mask(input logic [3:0] f);
        return (f == 4'd0) ? 15'd0 : (15'd1 << (f - 4'd1));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // The FIFO must never exceed DEPTH entries.
    always @(negedge clock) begin
        if (reset === 1'b0 && dut.u_fifo.count > 3'(DEPTH)) begin
            errors++;
            $display("FAIL fifo_overflow: occupancy %0d exceeds %0d", dut.u_fifo.count, DEPTH);
        end
    end

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_flip = '0; out_ready = 1'b0;
        step(); step();
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_ham !== 15'h0)  begin errors++; $display("FAIL rst_out_ham: got %h want 0000", out_ham); end
        reset = 1'b0; #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL post_rst_count: got %0d want 0", word_count); end
    endtask

    task automatic test_latency();
        logic [11:1] d [2];
        logic [15:1] e [2];
        d[0] = 11'h000; e[0] = 15'h0000;
        d[1] = 11'h7FF; e[1] = 15'h7FFF;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = d[i]; in_flip = 4'd0; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready[%0d]: got %b want 1", i, in_ready); end
            step();
            in_valid = 1'b0; in_data = 11'h555; in_flip = 4'd9; #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid[%0d]: got %b want 0", i, out_valid); end
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_ham !== e[i])   begin errors++; $display("FAIL lat_ham[%0d]: got %h want %h", i, out_ham, e[i]); end
            step(); exp_count++;
            checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL lat_drained[%0d]: got %b want 0", i, out_valid); end
            checks++; if (word_count !== exp_count) begin errors++; $display("FAIL lat_count[%0d]: got %0d want %0d", i, word_count, exp_count); end
        end
    endtask

    task automatic test_flip();
        out_ready = 1'b1;
        foreach (flip_vecs[i]) begin
            in_valid = 1'b1; in_data = flip_vecs[i].data; in_flip = flip_vecs[i].flip;
            step();
            in_valid = 1'b0;
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flip_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_ham !== flip_vecs[i].code) begin errors++; $display("FAIL flip_ham[%0d]: got %h want %h", i, out_ham, flip_vecs[i].code); end
            checks++; if (hamfix(out_ham) !== enc_model(flip_vecs[i].data)) begin
                errors++; $display("FAIL flip_hamfix[%0d]: got %h want %h", i, hamfix(out_ham), enc_model(flip_vecs[i].data));
            end
            step(); exp_count++;
        end
        checks++; if (word_count !== exp_count) begin errors++; $display("FAIL flip_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_backpressure();
        logic [15:1] bp_exp [4];
        int unsigned accepted = 0;
        bp_exp[0] = 15'h0007; bp_exp[1] = 15'h0019; bp_exp[2] = 15'h001E; bp_exp[3] = 15'h002A;
        out_ready = 1'b0; in_valid = 1'b1; in_flip = 4'd0;
        for (int c = 0; c < 10; c++) begin
            in_data = 11'(accepted + 1); #1;
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0; #1;
        checks++; if (accepted != 4)        begin errors++; $display("FAIL bp_accepted: got %0d want 4", accepted); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (out_ham !== 15'h0007) begin errors++; $display("FAIL bp_hold: got %h want 0007", out_ham); end
        out_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_ham !== bp_exp[i]) begin errors++; $display("FAIL bp_drain_ham[%0d]: got %h want %h", i, out_ham, bp_exp[i]); end
            step(); exp_count++;
        end
        checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        checks++; if (word_count !== exp_count) begin errors++; $display("FAIL bp_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:1] q [$];
        int unsigned next = 100;
        out_ready = 1'b0; in_valid = 1'b1; in_flip = 4'd0;
        for (int c = 0; c < 6; c++) begin
            in_data = 11'(next); #1;
            if (in_ready) begin q.push_back(enc_model(11'(next))); next++; end
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_data = 11'(next); #1;
            if (c >= 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, in_ready); end
            end
            if (in_ready) begin q.push_back(enc_model(11'(next))); next++; end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", c, out_valid); end
            if (q.size() == 0) begin
                errors++; $display("FAIL b2b_underflow[%0d]: got output want none", c);
            end else begin
                checks++; if (out_ham !== q[0]) begin errors++; $display("FAIL b2b_ham[%0d]: got %h want %h", c, out_ham, q[0]); end
                void'(q.pop_front());
            end
            step(); exp_count++;
            checks++; if (word_count !== exp_count) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", c, word_count, exp_count); end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                checks++; if (out_ham !== q[0]) begin errors++; $display("FAIL b2b_drain_ham[%0d]: got %h want %h", c, out_ham, q[0]); end
                void'(q.pop_front());
                exp_count++;
            end
            step();
        end
        checks++; if (q.size() != 0)             begin errors++; $display("FAIL b2b_drain_left: got %0d want 0", q.size()); end
        checks++; if (word_count !== exp_count) begin errors++; $display("FAIL b2b_drain_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        int unsigned accepted = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_flip = 4'd0;
        for (int c = 0; c < 10 && accepted < 4; c++) begin
            in_data = 11'(200 + accepted); #1;
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0; reset = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_rst_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rm_rst_ready: got %b want 0", in_ready); end
        checks++; if (out_ham !== 15'h0)  begin errors++; $display("FAIL rm_rst_ham: got %h want 0000", out_ham); end
        step();
        reset = 1'b0; exp_count = '0; #1;
        checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL rm_valid: got %b want 0", out_valid); end
        checks++; if (word_count !== exp_count) begin errors++; $display("FAIL rm_count: got %0d want 0", word_count); end
        checks++; if (in_ready !== 1'b1)        begin errors++; $display("FAIL rm_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: got %b want 0", out_valid); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 11'h123; in_flip = 4'd0;
        step();
        in_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_early: got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_lat_valid: got %b want 1", out_valid); end
        checks++; if (out_ham !== enc_model(11'h123)) begin errors++; $display("FAIL rm_lat_ham: got %h want %h", out_ham, enc_model(11'h123)); end
        step(); exp_count++;
        checks++; if (word_count !== exp_count) begin errors++; $display("FAIL rm_lat_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_random();
        logic [15:1] exp_q [$];
        logic [15:1] clean_q [$];
        logic [15:1] clean;
        int unsigned sent = 0;
        int unsigned cyc = 0;
        while ((sent < 10000 || exp_q.size() != 0) && cyc < 80000) begin
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            in_data   = 11'($urandom);
            in_flip   = 4'($urandom_range(15));
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (in_valid && in_ready) begin
                clean = enc_model(in_data);
                clean_q.push_back(clean);
                exp_q.push_back(clean ^ flip_mask(in_flip));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected: got %h want none", out_ham);
                end else begin
                    checks++; if (out_ham !== exp_q[0]) begin errors++; $display("FAIL rnd_ham: got %h want %h", out_ham, exp_q[0]); end
                    checks++; if (hamfix(out_ham) !== clean_q[0]) begin errors++; $display("FAIL rnd_hamfix: got %h want %h", hamfix(out_ham), clean_q[0]); end
                    void'(exp_q.pop_front());
                    void'(clean_q.pop_front());
                end
                exp_count++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; #1;
        checks++; if (exp_q.size() != 0)         begin errors++; $display("FAIL rnd_timeout: got %0d pending want 0", exp_q.size()); end
        checks++; if (word_count !== exp_count) begin errors++; $display("FAIL rnd_count: got %0d want %0d", word_count, exp_count); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_flip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
